uart_tx_sched: RTL and testbench

Shares one 8N1 UART transmit line between NREQ requesters using round-robin arbitration. Owns the bit-period timing via a clock-enable tick derived from SYSCLK/BAUDRATE, so no derived clock is used. Accepts one byte per grant, serialises it LSB-first on txd, and signals completion to the owning requester. Sits between on-chip byte producers (status/debug sources) and the board TX pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx_sched.sv | 127 ++++++++++++
 tb/tb_uart_tx_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the shared UART transmitter.
//   state_t           - transmitter frame state (IDLE/START/DATA/STOP)
//   FRAME_BITS        - line bits per 8N1 frame (start + 8 data + stop)
//   calc_clks_per_bit - system clocks per line bit, integer division
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;

  function automatic int calc_clks_per_bit(input int sysclk, input int baudrate);
    return sysclk / baudrate;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period clock enable.
//   clk     - system clock
//   rst     - synchronous active-high reset
//   restart - clears the counter so a new frame starts on a clean bit boundary
//   tick    - high for one cycle on the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one 8N1 UART TX line.
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   req   - per-requester level request, held until gnt
//   data  - byte for requester i on data[8*i+7:8*i]
//   gnt   - one-cycle pulse: that requester's byte was accepted
//   done  - one-cycle pulse: that requester's stop bit finished
//   busy  - high from grant until the end of the stop bit
//   owner - current or most recent granted requester
//   txd   - serial line, idles high
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int SYSCLK   = 100_000_000,
  parameter int BAUDRATE = 9600,
  parameter int NREQ     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [1:0]        owner,
  output logic              txd
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(SYSCLK, BAUDRATE);

  state_t     state;
  logic [1:0] last;      // round-robin pointer: last granted requester
  logic [7:0] shreg;     // remaining data bits, LSB goes out next
  logic [2:0] bit_idx;
  logic       tick;
  logic       restart;
  logic       pick_valid;
  logic [1:0] pick;

  // Search order starts just after the last owner and wraps modulo NREQ.
  // NOTE: every always_comb output gets a default before the loop so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    logic [1:0] cand;
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = 2'((int'(last) + i) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  assign restart = (state == IDLE) && pick_valid;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      owner   <= '0;
      last    <= 2'(NREQ - 1);
      // NOTE: the shift register is plain datapath and is always loaded
      // before use; it is reset only to keep simulation free of X.
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pick_valid) begin
            shreg <= data[8*pick +: 8];
            owner <= pick;
            last  <= pick;
            gnt   <= NREQ'(1) << pick;
            busy  <= 1'b1;
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            done  <= NREQ'(1) << owner;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: self-checking bench for uart_tx_sched with
// SYSCLK=16, BAUDRATE=4 (4 clocks per bit) and NREQ=4.
module tb_uart_tx_sched;

  localparam int NREQ  = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  owner;
  logic        txd;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .SYSCLK   (16),
    .BAUDRATE (4),
    .NREQ     (NREQ)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .data  (data),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .owner (owner),
    .txd   (txd)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         idx;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          pulse_k;
    logic [3:0]  pulse_req;
    logic [31:0] pulse_data;
    int          exp_idx;
    logic [7:0]  exp_val;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int waited, output logic ok);
    waited = -1;
    ok     = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      step();
      if (gnt != '0) begin
        waited = c;
        ok     = 1'b1;
        break;
      end
    end
  endtask

  // Waits for a grant, pops the expected owner/byte and checks the whole
  // frame cycle by cycle. Optionally changes req/data at frame cycle pulse_k
  // (req returns to 0 one cycle later). Returns on the done cycle.
  task automatic serve_frame(input logic drop_req, input int pulse_k,
                             input logic [3:0] pulse_req, input logic [31:0] pulse_data,
                             output int waited);
    logic  ok;
    exp_t  e;
    logic  exp_bit;
    wait_grant(waited, ok);
    check("grant_seen", 32'(ok), 1);
    if (!ok) return;
    check("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("gnt", 32'(gnt), 32'(1) << e.idx);
    check("owner", 32'(owner), 32'(e.idx));
    check("busy_at_gnt", 32'(busy), 1);
    if (drop_req) req = '0;
    for (int k = 0; k < FRAME; k++) begin
      if (k == pulse_k) begin
        req  = pulse_req;
        data = pulse_data;
      end else if (pulse_k >= 0 && k == pulse_k + 1) begin
        req = '0;
      end
      if (k < CPB)           exp_bit = 1'b0;
      else if (k < 9 * CPB)  exp_bit = e.val[(k - CPB) / CPB];
      else                   exp_bit = 1'b1;
      check($sformatf("txd k=%0d", k), 32'(txd), 32'(exp_bit));
      if (k == FRAME - 1) check("busy_last", 32'(busy), 1);
      step();
    end
    check("done", 32'(done), 32'(1) << e.idx);
    check("busy_at_done", 32'(busy), 0);
    check("txd_at_done", 32'(txd), 1);
  endtask

  task automatic idle_check(input int n);
    logic [3:0] gnt_seen;
    logic       txd_low;
    logic       busy_seen;
    gnt_seen  = '0;
    txd_low   = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      step();
      gnt_seen  = gnt_seen | gnt;
      txd_low   = txd_low | ~txd;
      busy_seen = busy_seen | busy;
    end
    check("idle_gnt", 32'(gnt_seen), 0);
    check("idle_txd_low", 32'(txd_low), 0);
    check("idle_busy", 32'(busy_seen), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         waited;
    logic       ok;
    logic [3:0] done_seen;

    // Single-requester transactions, including late data change and a
    // short request pulse from another requester while busy.
    vecs[0] = '{4'b0001, 32'h0000_00A5, -1, 4'b0000, 32'h0, 0, 8'hA5};
    vecs[1] = '{4'b0010, 32'h0000_3C00, -1, 4'b0000, 32'h0, 1, 8'h3C};
    vecs[2] = '{4'b0001, 32'h1122_3300,  0, 4'b0000, 32'h1122_33FF, 0, 8'h00};
    vecs[3] = '{4'b0001, 32'h00EE_005A, 10, 4'b0100, 32'h00EE_005A, 0, 8'h5A};
    vecs[4] = '{4'b1000, 32'h8100_0000, -1, 4'b0000, 32'h0, 3, 8'h81};
    vecs[5] = '{4'b0100, 32'h00C3_0000, -1, 4'b0000, 32'h0, 2, 8'hC3};

    rst  = 1'b1;
    req  = '0;
    data = '0;
    step();
    step();
    check("rst_txd", 32'(txd), 1);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    rst = 1'b0;
    idle_check(3);

    for (int i = 0; i < 6; i++) begin
      req  = vecs[i].req;
      data = vecs[i].data;
      sb.push_back('{vecs[i].exp_idx, vecs[i].exp_val});
      serve_frame(1'b1, vecs[i].pulse_k, vecs[i].pulse_req, vecs[i].pulse_data, waited);
      check("grant_latency", 32'(waited), 1);
      idle_check(8);
    end

    // All four requesting: round-robin from reset, back-to-back with a
    // single idle-high cycle between done and the next start bit.
    do_reset();
    data = 32'h4433_2211;
    req  = 4'b1111;
    sb.push_back('{0, 8'h11});
    sb.push_back('{1, 8'h22});
    sb.push_back('{2, 8'h33});
    sb.push_back('{3, 8'h44});
    sb.push_back('{0, 8'h11});
    for (int f = 0; f < 5; f++) begin
      serve_frame(1'b0, -1, 4'b0000, 32'h0, waited);
      check("b2b_gap", 32'(waited), 1);
    end
    req = '0;
    idle_check(6);

    // Reset in the middle of a frame owned by requester 1.
    do_reset();
    data = 32'h0000_0700;
    req  = 4'b0010;
    wait_grant(waited, ok);
    check("abort_gnt", 32'(gnt), 32'b0010);
    req = '0;
    repeat (17) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_txd", 32'(txd), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_owner", 32'(owner), 0);
    done_seen = '0;
    for (int c = 0; c < FRAME + 10; c++) begin
      step();
      done_seen = done_seen | done;
    end
    check("abort_no_done", 32'(done_seen), 0);

    // Pointer was reset: req[0] beats req[3]; then req[3] alone is served.
    data = 32'hB700_0042;
    req  = 4'b1001;
    sb.push_back('{0, 8'h42});
    serve_frame(1'b1, -1, 4'b0000, 32'h0, waited);
    req = 4'b1000;
    sb.push_back('{3, 8'hB7});
    serve_frame(1'b1, -1, 4'b0000, 32'h0, waited);
    idle_check(4);

    // After owner 1, requests from 3 and 1 together: 3 goes first.
    do_reset();
    data = 32'h6C00_9600;
    req  = 4'b0010;
    sb.push_back('{1, 8'h96});
    serve_frame(1'b1, -1, 4'b0000, 32'h0, waited);
    idle_check(4);
    req = 4'b1010;
    sb.push_back('{3, 8'h6C});
    sb.push_back('{1, 8'h96});
    serve_frame(1'b0, -1, 4'b0000, 32'h0, waited);
    serve_frame(1'b0, -1, 4'b0000, 32'h0, waited);
    check("rr_gap", 32'(waited), 1);
    req = '0;
    idle_check(6);
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
